control_unit: RTL and testbench
===============================

Name: control_unit

Overview: Instruction decoder for the vector ASIP core. It takes the 2-bit opcode class `op`, the 2-bit sub-instruction `inst`, the vector flag `VF` and the stored compare flag `flagV`. From these it produces the memory, register-file, flag, jump, ALU and immediate-extender controls for the datapath. Decoding is combinational and the outputs are registered, so the controls reach the execute stage one cycle after the instruction fields are sampled.

Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  2  opcode class
- inst  in  2  sub-instruction within the class
- flagV  in  1  stored equal flag from the last CMPR/CMPI (1 = equal)
- VF  in  1  vector-instruction flag (1 = vector variant)
- wmem  out  1  data-memory write enable
- rmem  out  1  data-memory read enable
- wreg  out  1  register-file write enable
- CondEn  out  1  compare-flag register write enable
- jmpSel  out  1  next-PC select (1 = jump target, 0 = PC+1)
- jmpF  out  2  jump function: 00 none, 01 JMP, 10 JEQ, 11 STL (stall/halt)
- ALUins  out  3  ALU operation: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 PASS-B; 101–111 unused
- ExtndSel  out  2  immediate extender: 00 none/zero, 01 memory offset, 10 data immediate, 11 jump target

Behaviour:
- Timing
  - All outputs are registered, updating on the rising edge of clk.
  - Outputs reflect op/inst/VF/flagV sampled at that edge, so latency is 1 cycle. There is no other state.
- Reset
  - rst=1 at a rising edge forces every output to 0 (NOP) that cycle, overriding the decode.
  - The first decoded output appears on the edge after rst is deasserted.
  - Asserting rst mid-stream discards the instruction sampled at that edge.
- Default rule: any output not listed for an instruction is 0.
- Scalar decode (VF=0), listed as op/inst:
  - 01/00 STR: wmem=1, ExtndSel=01, ALUins=000 (address = base + offset).
  - 11/01 LDR: rmem=1, wreg=1, ExtndSel=01, ALUins=000.
  - 11/10 MOVR: wreg=1, ALUins=100.
  - 11/11 MOVI: wreg=1, ALUins=100, ExtndSel=10.
  - 10/00 ADD: wreg=1, ALUins=000.
  - 10/01 SUB: wreg=1, ALUins=001.
  - 10/10 MUL: wreg=1, ALUins=010.
  - 10/11 DIV: wreg=1, ALUins=011.
  - 01/01 CMPR: CondEn=1, ALUins=001, wreg=0.
  - 01/10 CMPI: CondEn=1, ALUins=001, ExtndSel=10.
  - 00/00 JMP: jmpF=01, jmpSel=1, ExtndSel=11.
  - 00/01 JEQ: jmpF=10, jmpSel=flagV, ExtndSel=11.
  - 00/10 STL: jmpF=11, jmpSel=0, all enables 0.
  - 01/11, 11/00 and 00/11 are illegal and decode as NOP (all outputs 0).
- Vector decode (VF=1), same enables/ALUins/ExtndSel as the scalar counterpart:
  - 01/00 STRV = STR.
  - 11/01 LDRV = LDR.
  - 10/00 ADDVV = ADD.
  - 10/01 SUBVV = SUB.
  - 10/10 MULVE = MUL.
  - 10/11 DIVVE = DIV.
  - Every other op/inst with VF=1 (vector compare, move, jump, STL) is illegal and decodes as NOP.
- flagV affects only jmpSel, and only for JEQ. It is sampled at the same edge as op/inst.
- Exclusivity invariants:
  - wmem and rmem are never both 1.
  - wreg and CondEn are never both 1.
  - jmpF≠00 implies wmem=rmem=wreg=CondEn=0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with op/inst=10/00 -> all outputs 0. Release rst -> on the next edge wreg=1, ALUins=000.
- Scalar sweep, VF=0, flagV=0, one instruction per cycle: STR, LDR, MOVR, MOVI, ADD, SUB, MUL, DIV, CMPR, CMPI, JMP, JEQ, STL -> each output set matches the table one cycle later. Spot checks:
  - STR gives wmem=1, ExtndSel=01.
  - CMPI gives CondEn=1, ALUins=001, ExtndSel=10.
  - JEQ gives jmpF=10, jmpSel=0.
- JEQ condition: op/inst=00/01 with flagV=1 -> jmpSel=1, jmpF=10, ExtndSel=11. Toggle flagV to 0 -> jmpSel=0 next cycle.
- Vector sweep, VF=1: STRV, LDRV, ADDVV, SUBVV, MULVE, DIVVE -> outputs identical to STR, LDR, ADD, SUB, MUL, DIV. Specifically:
  - LDRV gives rmem=1, wreg=1.
  - DIVVE gives ALUins=011.
- Illegal encodings: VF=0 with 01/11, 11/00, 00/11; VF=1 with 01/01 and 00/00 -> all outputs 0.
- Invariants: check every cycle in a random op/inst/VF/flagV run (≥1000 cycles) that the exclusivity invariants hold and that outputs equal a reference decode of the previous cycle's inputs.

Source files
------------

// File: rtl/control_unit.sv
// Instruction decoder for the vector ASIP core: decodes op/inst/VF/flagV
// combinationally and registers every control so it reaches execute one cycle later.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] op,
    input  logic [1:0] inst,
    input  logic       flagV,
    input  logic       VF,
    output logic       wmem,
    output logic       rmem,
    output logic       wreg,
    output logic       CondEn,
    output logic       jmpSel,
    output logic [1:0] jmpF,
    output logic [2:0] ALUins,
    output logic [1:0] ExtndSel
);

    localparam logic [1:0] OP_JUMP  = 2'b00;
    localparam logic [1:0] OP_MEMCMP = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_LDMOV = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_PASS = 3'b100;

    localparam logic [1:0] EXT_NONE = 2'b00;
    localparam logic [1:0] EXT_MEM  = 2'b01;
    localparam logic [1:0] EXT_DATA = 2'b10;
    localparam logic [1:0] EXT_JMP  = 2'b11;

    localparam logic [1:0] JF_NONE = 2'b00;
    localparam logic [1:0] JF_JMP  = 2'b01;
    localparam logic [1:0] JF_JEQ  = 2'b10;
    localparam logic [1:0] JF_STL  = 2'b11;

    logic       wmem_d;
    logic       rmem_d;
    logic       wreg_d;
    logic       cond_en_d;
    logic       jmp_sel_d;
    logic [1:0] jmp_f_d;
    logic [2:0] alu_ins_d;
    logic [1:0] extnd_sel_d;

    always_comb begin
        wmem_d      = 1'b0;
        rmem_d      = 1'b0;
        wreg_d      = 1'b0;
        cond_en_d   = 1'b0;
        jmp_sel_d   = 1'b0;
        jmp_f_d     = JF_NONE;
        alu_ins_d   = ALU_ADD;
        extnd_sel_d = EXT_NONE;
        case (op)
            OP_ARITH: begin
                // ADD/SUB/MUL/DIV and their vector forms map inst straight onto the ALU code
                wreg_d    = 1'b1;
                alu_ins_d = {1'b0, inst};
            end
            OP_MEMCMP: begin
                if (inst == 2'b00) begin
                    wmem_d      = 1'b1;
                    extnd_sel_d = EXT_MEM;
                end else if (!VF && inst == 2'b01) begin
                    cond_en_d = 1'b1;
                    alu_ins_d = ALU_SUB;
                end else if (!VF && inst == 2'b10) begin
                    cond_en_d   = 1'b1;
                    alu_ins_d   = ALU_SUB;
                    extnd_sel_d = EXT_DATA;
                end
            end
            OP_LDMOV: begin
                if (inst == 2'b01) begin
                    rmem_d      = 1'b1;
                    wreg_d      = 1'b1;
                    extnd_sel_d = EXT_MEM;
                end else if (!VF && inst == 2'b10) begin
                    wreg_d    = 1'b1;
                    alu_ins_d = ALU_PASS;
                end else if (!VF && inst == 2'b11) begin
                    wreg_d      = 1'b1;
                    alu_ins_d   = ALU_PASS;
                    extnd_sel_d = EXT_DATA;
                end
            end
            default: begin
                // Jump class exists only as scalar instructions
                if (!VF) begin
                    case (inst)
                        2'b00: begin
                            jmp_f_d     = JF_JMP;
                            jmp_sel_d   = 1'b1;
                            extnd_sel_d = EXT_JMP;
                        end
                        2'b01: begin
                            jmp_f_d     = JF_JEQ;
                            jmp_sel_d   = flagV;
                            extnd_sel_d = EXT_JMP;
                        end
                        2'b10: jmp_f_d = JF_STL;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wmem     <= 1'b0;
            rmem     <= 1'b0;
            wreg     <= 1'b0;
            CondEn   <= 1'b0;
            jmpSel   <= 1'b0;
            jmpF     <= JF_NONE;
            ALUins   <= ALU_ADD;
            ExtndSel <= EXT_NONE;
        end else begin
            wmem     <= wmem_d;
            rmem     <= rmem_d;
            wreg     <= wreg_d;
            CondEn   <= cond_en_d;
            jmpSel   <= jmp_sel_d;
            jmpF     <= jmp_f_d;
            ALUins   <= alu_ins_d;
            ExtndSel <= extnd_sel_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomized checks of the control_unit decode table, reset and latency.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [1:0] op;
    logic [1:0] inst;
    logic       flagV;
    logic       VF;
    logic       wmem;
    logic       rmem;
    logic       wreg;
    logic       CondEn;
    logic       jmpSel;
    logic [1:0] jmpF;
    logic [2:0] ALUins;
    logic [1:0] ExtndSel;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    control_unit dut (
        .clk(clk), .rst(rst), .op(op), .inst(inst), .flagV(flagV), .VF(VF),
        .wmem(wmem), .rmem(rmem), .wreg(wreg), .CondEn(CondEn), .jmpSel(jmpSel),
        .jmpF(jmpF), .ALUins(ALUins), .ExtndSel(ExtndSel)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {wmem, rmem, wreg, CondEn, jmpSel, jmpF, ALUins, ExtndSel}
    function automatic logic [11:0] pk(input logic wm, input logic rm, input logic wr,
                                       input logic ce, input logic js, input logic [1:0] jf,
                                       input logic [2:0] alu, input logic [1:0] ext);
        return {wm, rm, wr, ce, js, jf, alu, ext};
    endfunction

    function automatic logic [11:0] observed();
        return {wmem, rmem, wreg, CondEn, jmpSel, jmpF, ALUins, ExtndSel};
    endfunction

    // Reference decode written as one flat table over {VF, op, inst}
    function automatic logic [11:0] ref_decode(input logic v, input logic [1:0] o,
                                               input logic [1:0] i, input logic fv);
        case ({v, o, i})
            5'b0_01_00, 5'b1_01_00: return pk(1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01);
            5'b0_11_01, 5'b1_11_01: return pk(0, 1, 1, 0, 0, 2'b00, 3'b000, 2'b01);
            5'b0_11_10:             return pk(0, 0, 1, 0, 0, 2'b00, 3'b100, 2'b00);
            5'b0_11_11:             return pk(0, 0, 1, 0, 0, 2'b00, 3'b100, 2'b10);
            5'b0_10_00, 5'b1_10_00: return pk(0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00);
            5'b0_10_01, 5'b1_10_01: return pk(0, 0, 1, 0, 0, 2'b00, 3'b001, 2'b00);
            5'b0_10_10, 5'b1_10_10: return pk(0, 0, 1, 0, 0, 2'b00, 3'b010, 2'b00);
            5'b0_10_11, 5'b1_10_11: return pk(0, 0, 1, 0, 0, 2'b00, 3'b011, 2'b00);
            5'b0_01_01:             return pk(0, 0, 0, 1, 0, 2'b00, 3'b001, 2'b00);
            5'b0_01_10:             return pk(0, 0, 0, 1, 0, 2'b00, 3'b001, 2'b10);
            5'b0_00_00:             return pk(0, 0, 0, 0, 1, 2'b01, 3'b000, 2'b11);
            5'b0_00_01:             return pk(0, 0, 0, 0, fv, 2'b10, 3'b000, 2'b11);
            5'b0_00_10:             return pk(0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00);
            default:                return 12'h000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs, expv);
        end
    endtask

    // driver: apply fields at negedge, compare one edge later against a hand value
    task automatic step(input string tag, input logic r, input logic [1:0] o, input logic [1:0] i,
                        input logic v, input logic fv, input logic [11:0] expv);
        @(negedge clk);
        rst = r; op = o; inst = i; VF = v; flagV = fv;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        check(tag, observed(), exp_q.pop_front());
    endtask

    task automatic check_invariants(input string tag);
        checks++;
        assert (!(wmem && rmem) && !(wreg && CondEn) &&
                (jmpF == 2'b00 || {wmem, rmem, wreg, CondEn} == 4'b0000)) else begin
            errors++;
            $error("FAIL %s observed=%03h expected=exclusive_controls", tag, observed());
        end
    endtask

    localparam logic [11:0] E_STR  = 12'b1_0_0_0_0_00_000_01;
    localparam logic [11:0] E_LDR  = 12'b0_1_1_0_0_00_000_01;
    localparam logic [11:0] E_MOVR = 12'b0_0_1_0_0_00_100_00;
    localparam logic [11:0] E_MOVI = 12'b0_0_1_0_0_00_100_10;
    localparam logic [11:0] E_ADD  = 12'b0_0_1_0_0_00_000_00;
    localparam logic [11:0] E_SUB  = 12'b0_0_1_0_0_00_001_00;
    localparam logic [11:0] E_MUL  = 12'b0_0_1_0_0_00_010_00;
    localparam logic [11:0] E_DIV  = 12'b0_0_1_0_0_00_011_00;
    localparam logic [11:0] E_CMPR = 12'b0_0_0_1_0_00_001_00;
    localparam logic [11:0] E_CMPI = 12'b0_0_0_1_0_00_001_10;
    localparam logic [11:0] E_JMP  = 12'b0_0_0_0_1_01_000_11;
    localparam logic [11:0] E_JEQ0 = 12'b0_0_0_0_0_10_000_11;
    localparam logic [11:0] E_JEQ1 = 12'b0_0_0_0_1_10_000_11;
    localparam logic [11:0] E_STL  = 12'b0_0_0_0_0_11_000_00;
    localparam logic [11:0] E_NOP  = 12'h000;

    initial begin
        logic [11:0] expv;
        logic        r_n;
        logic [1:0]  o_n;
        logic [1:0]  i_n;
        logic        v_n;
        logic        f_n;
        rst = 1'b1; op = 2'b10; inst = 2'b00; VF = 1'b0; flagV = 1'b0;

        // reset holds NOP, then first decode one edge after release
        step("reset_0", 1, 2'b10, 2'b00, 0, 0, E_NOP);
        step("reset_1", 1, 2'b10, 2'b00, 0, 0, E_NOP);
        step("first_add", 0, 2'b10, 2'b00, 0, 0, E_ADD);

        // scalar sweep
        step("STR",  0, 2'b01, 2'b00, 0, 0, E_STR);
        step("LDR",  0, 2'b11, 2'b01, 0, 0, E_LDR);
        step("MOVR", 0, 2'b11, 2'b10, 0, 0, E_MOVR);
        step("MOVI", 0, 2'b11, 2'b11, 0, 0, E_MOVI);
        step("ADD",  0, 2'b10, 2'b00, 0, 0, E_ADD);
        step("SUB",  0, 2'b10, 2'b01, 0, 0, E_SUB);
        step("MUL",  0, 2'b10, 2'b10, 0, 0, E_MUL);
        step("DIV",  0, 2'b10, 2'b11, 0, 0, E_DIV);
        step("CMPR", 0, 2'b01, 2'b01, 0, 0, E_CMPR);
        step("CMPI", 0, 2'b01, 2'b10, 0, 0, E_CMPI);
        step("JMP",  0, 2'b00, 2'b00, 0, 0, E_JMP);
        step("JEQ",  0, 2'b00, 2'b01, 0, 0, E_JEQ0);
        step("STL",  0, 2'b00, 2'b10, 0, 0, E_STL);

        // JEQ taken / not taken
        step("JEQ_taken",    0, 2'b00, 2'b01, 0, 1, E_JEQ1);
        step("JEQ_nottaken", 0, 2'b00, 2'b01, 0, 0, E_JEQ0);
        step("JMP_flag1",    0, 2'b00, 2'b00, 0, 1, E_JMP);
        step("ADD_flag1",    0, 2'b10, 2'b00, 0, 1, E_ADD);

        // vector sweep
        step("STRV",  0, 2'b01, 2'b00, 1, 0, E_STR);
        step("LDRV",  0, 2'b11, 2'b01, 1, 0, E_LDR);
        step("ADDVV", 0, 2'b10, 2'b00, 1, 0, E_ADD);
        step("SUBVV", 0, 2'b10, 2'b01, 1, 0, E_SUB);
        step("MULVE", 0, 2'b10, 2'b10, 1, 0, E_MUL);
        step("DIVVE", 0, 2'b10, 2'b11, 1, 0, E_DIV);

        // illegal encodings
        step("ill_s_0111", 0, 2'b01, 2'b11, 0, 0, E_NOP);
        step("ill_s_1100", 0, 2'b11, 2'b00, 0, 0, E_NOP);
        step("ill_s_0011", 0, 2'b00, 2'b11, 0, 1, E_NOP);
        step("ill_v_0101", 0, 2'b01, 2'b01, 1, 0, E_NOP);
        step("ill_v_0000", 0, 2'b00, 2'b00, 1, 1, E_NOP);
        step("ill_v_jeq",  0, 2'b00, 2'b01, 1, 1, E_NOP);
        step("ill_v_movi", 0, 2'b11, 2'b11, 1, 0, E_NOP);
        step("ill_v_cmpi", 0, 2'b01, 2'b10, 1, 0, E_NOP);

        // mid-stream reset discards the sampled instruction
        step("mid_rst", 1, 2'b11, 2'b01, 0, 0, E_NOP);
        step("after_rst", 0, 2'b01, 2'b00, 0, 0, E_STR);

        // random run: scoreboard against the reference decode plus invariants
        @(negedge clk);
        rst = 1'b0; op = 2'b00; inst = 2'b10; VF = 1'b0; flagV = 1'b0;
        exp_q.push_back(E_STL);
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            check("rand_decode", observed(), exp_q.pop_front());
            check_invariants("rand_invariant");
            r_n = ($urandom_range(0, 31) == 0);
            o_n = 2'($urandom_range(0, 3));
            i_n = 2'($urandom_range(0, 3));
            v_n = 1'($urandom_range(0, 1));
            f_n = 1'($urandom_range(0, 1));
            rst = r_n; op = o_n; inst = i_n; VF = v_n; flagV = f_n;
            expv = r_n ? E_NOP : ref_decode(v_n, o_n, i_n, f_n);
            exp_q.push_back(expv);
        end
        @(negedge clk);
        check("rand_last", observed(), exp_q.pop_front());

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
